// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control slice.
// Control word, bubble value, forward and redirect encodings.
package pipe_pkg;

  typedef logic [4:0] reg_t;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] REDIR_NONE   = 2'b00;
  localparam logic [1:0] REDIR_JUMP   = 2'b01;
  localparam logic [1:0] REDIR_JR     = 2'b10;
  localparam logic [1:0] REDIR_BRANCH = 2'b11;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between decoder/datapath (master) and pipeline_ctrl (slave).
// Master drives ID fields and ex_zero; slave drives hazard/fwd/ctrl/counters.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_pkg::*;

  reg_t id_rs;
  reg_t id_rt;
  reg_t id_rd;
  logic id_regdest;
  logic id_regwrite;
  logic id_memread;
  logic id_memwrite;
  logic id_memtoreg;
  logic id_branch;
  logic id_jump;
  logic id_jump_return;
  logic ex_zero;

  logic       stall;
  logic       flush_ifid;
  logic [1:0] pc_redirect;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       ex_memread;
  logic       ex_memwrite;
  logic       ex_memtoreg;
  logic       ex_regwrite;
  logic       mem_memread;
  logic       mem_memwrite;
  logic       wb_regwrite;
  logic       wb_memtoreg;
  reg_t       wb_wreg;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_rd,
    output id_regdest, id_regwrite,
    output id_memread, id_memwrite,
    output id_memtoreg, id_branch,
    output id_jump, id_jump_return,
    output ex_zero,
    input  stall, flush_ifid, pc_redirect,
    input  forward_a, forward_b,
    input  ex_memread, ex_memwrite,
    input  ex_memtoreg, ex_regwrite,
    input  mem_memread, mem_memwrite,
    input  wb_regwrite, wb_memtoreg, wb_wreg,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rd,
    input  id_regdest, id_regwrite,
    input  id_memread, id_memwrite,
    input  id_memtoreg, id_branch,
    input  id_jump, id_jump_return,
    input  ex_zero,
    output stall, flush_ifid, pc_redirect,
    output forward_a, forward_b,
    output ex_memread, ex_memwrite,
    output ex_memtoreg, ex_regwrite,
    output mem_memread, mem_memwrite,
    output wb_regwrite, wb_memtoreg, wb_wreg,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fwd_sel.sv
// One EX operand's forwarding select; MEM result beats WB result.
// Ports: src operand reg, MEM/WB regwrite+dest, sel (FWD_* code).
module fwd_sel
  import pipe_pkg::*;
(
  input  reg_t       src,
  input  logic       mem_rw,
  input  reg_t       mem_wreg,
  input  logic       wb_rw,
  input  reg_t       wb_wreg,
  output logic [1:0] sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_rw && (mem_wreg != '0)
                && (mem_wreg == src);
  // WB only counts when MEM does not already match.
  assign wb_hit  = wb_rw && (wb_wreg != '0)
                && (wb_wreg == src) && !mem_hit;

  always_comb begin
    sel = FWD_RF;
    unique case (1'b1)
      mem_hit: sel = FWD_MEM;
      wb_hit:  sel = FWD_WB;
      default: sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Carries decoded control through ID/EX, EX/MEM, MEM/WB; hazards,
// redirects, forwarding, perf counters. Ports: clk, reset, bus(slave).
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  pipeline_ctrl_if.slave bus
);

  ctrl_t id_ctrl;
  reg_t  id_wreg;

  ctrl_t ex_ctrl;
  reg_t  ex_wreg;
  reg_t  ex_rs;
  reg_t  ex_rt;

  logic  mem_rw;
  logic  mem_mr;
  logic  mem_mw;
  logic  mem_m2r;
  reg_t  mem_wreg;

  logic  wb_rw;
  logic  wb_m2r;
  reg_t  wb_wreg;

  logic  ld_use;
  logic  jr_haz;
  logic  taken;
  logic  stall;
  logic  flush;
  logic  id_kill;
  logic [1:0] redir;
  logic [1:0] fa;
  logic [1:0] fb;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign id_ctrl = '{
    regwrite: bus.id_regwrite,
    memread:  bus.id_memread,
    memwrite: bus.id_memwrite,
    memtoreg: bus.id_memtoreg,
    branch:   bus.id_branch
  };
  assign id_wreg = bus.id_regdest ? bus.id_rd : bus.id_rt;

  assign ld_use = ex_ctrl.memread && (ex_wreg != '0)
               && ((ex_wreg == bus.id_rs)
                || (ex_wreg == bus.id_rt));

  assign jr_haz = bus.id_jump_return && (bus.id_rs != '0)
               && ((ex_ctrl.regwrite && ex_wreg == bus.id_rs)
                || (mem_rw && mem_wreg == bus.id_rs));

  assign taken = ex_ctrl.branch && bus.ex_zero;

  // Taken branch wins over stalls and ID redirects.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    redir = REDIR_NONE;
    if (reset) begin
      stall = 1'b0;
    end else if (taken) begin
      flush = 1'b1;
      redir = REDIR_BRANCH;
    end else if (ld_use || jr_haz) begin
      stall = 1'b1;
    end else if (bus.id_jump) begin
      flush = 1'b1;
      redir = REDIR_JUMP;
    end else if (bus.id_jump_return) begin
      flush = 1'b1;
      redir = REDIR_JR;
    end
  end

  // Jumps enter EX as bubbles so they never write.
  assign id_kill = stall || taken
                || bus.id_jump || bus.id_jump_return;

  fwd_sel u_fwd_a (
    .src      (ex_rs),
    .mem_rw   (mem_rw),
    .mem_wreg (mem_wreg),
    .wb_rw    (wb_rw),
    .wb_wreg  (wb_wreg),
    .sel      (fa)
  );

  fwd_sel u_fwd_b (
    .src      (ex_rt),
    .mem_rw   (mem_rw),
    .mem_wreg (mem_wreg),
    .wb_rw    (wb_rw),
    .wb_wreg  (wb_wreg),
    .sel      (fb)
  );

  always_ff @(posedge clk) begin
    if (reset || id_kill) begin
      ex_ctrl <= CTRL_BUBBLE;
      ex_wreg <= '0;
      ex_rs   <= '0;
      ex_rt   <= '0;
    end else begin
      ex_ctrl <= id_ctrl;
      ex_wreg <= id_wreg;
      ex_rs   <= bus.id_rs;
      ex_rt   <= bus.id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rw   <= 1'b0;
      mem_mr   <= 1'b0;
      mem_mw   <= 1'b0;
      mem_m2r  <= 1'b0;
      mem_wreg <= '0;
      wb_rw    <= 1'b0;
      wb_m2r   <= 1'b0;
      wb_wreg  <= '0;
    end else begin
      mem_rw   <= ex_ctrl.regwrite;
      mem_mr   <= ex_ctrl.memread;
      mem_mw   <= ex_ctrl.memwrite;
      mem_m2r  <= ex_ctrl.memtoreg;
      mem_wreg <= ex_wreg;
      wb_rw    <= mem_rw;
      wb_m2r   <= mem_m2r;
      wb_wreg  <= mem_wreg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(stall);
      flush_q <= flush_q + CNT_W'(flush);
    end
  end

  assign bus.stall        = stall;
  assign bus.flush_ifid   = flush;
  assign bus.pc_redirect  = redir;
  assign bus.forward_a    = reset ? FWD_RF : fa;
  assign bus.forward_b    = reset ? FWD_RF : fb;
  assign bus.ex_memread   = ex_ctrl.memread;
  assign bus.ex_memwrite  = ex_ctrl.memwrite;
  assign bus.ex_memtoreg  = ex_ctrl.memtoreg;
  assign bus.ex_regwrite  = ex_ctrl.regwrite;
  assign bus.mem_memread  = mem_mr;
  assign bus.mem_memwrite = mem_mw;
  assign bus.wb_regwrite  = wb_rw;
  assign bus.wb_memtoreg  = wb_m2r;
  assign bus.wb_wreg      = wb_wreg;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, redirects, forwarding,
// counters and reset, with hand-computed expectations.
module tb_pipeline_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  // {regdest,regwrite,memread,memwrite,memtoreg,branch,jump,jr}
  localparam logic [7:0] C_NOP  = 8'b0000_0000;
  localparam logic [7:0] C_R    = 8'b1100_0000;
  localparam logic [7:0] C_LW   = 8'b0110_1000;
  localparam logic [7:0] C_ADDI = 8'b0100_0000;
  localparam logic [7:0] C_JR   = 8'b0000_0001;
  localparam logic [7:0] C_JAL  = 8'b0100_0010;
  localparam logic [7:0] C_BLD  = 8'b0010_0100;

  pipeline_ctrl_if #(.CNT_W(32)) bus ();

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idv(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [7:0] c
  );
    bus.id_rs = rs;
    bus.id_rt = rt;
    bus.id_rd = rd;
    {bus.id_regdest, bus.id_regwrite, bus.id_memread,
     bus.id_memwrite, bus.id_memtoreg, bus.id_branch,
     bus.id_jump, bus.id_jump_return} = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idv(5'd0, 5'd0, 5'd0, C_NOP);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ex_zero = 1'b0;
    idv(5'd0, 5'd0, 5'd0, C_NOP);
    tick();
    tick();
    total++; if (bus.stall !== 1'b0) $display("FAIL rst_stall got %0d want 0", bus.stall); else passed++;
    total++; if (bus.flush_ifid !== 1'b0) $display("FAIL rst_flush got %0d want 0", bus.flush_ifid); else passed++;
    total++; if (bus.pc_redirect !== 2'b00) $display("FAIL rst_redir got %0d want 0", bus.pc_redirect); else passed++;
    total++; if (bus.forward_a !== 2'b00) $display("FAIL rst_fa got %0d want 0", bus.forward_a); else passed++;
    total++; if (bus.forward_b !== 2'b00) $display("FAIL rst_fb got %0d want 0", bus.forward_b); else passed++;
    reset = 1'b0;
    #1;
    total++; if (bus.stall_cnt !== 32'd0) $display("FAIL rst_scnt got %0d want 0", bus.stall_cnt); else passed++;
    total++; if (bus.flush_cnt !== 32'd0) $display("FAIL rst_fcnt got %0d want 0", bus.flush_cnt); else passed++;
    total++; if (bus.ex_regwrite !== 1'b0) $display("FAIL rst_exrw got %0d want 0", bus.ex_regwrite); else passed++;
    total++; if (bus.wb_regwrite !== 1'b0) $display("FAIL rst_wbrw got %0d want 0", bus.wb_regwrite); else passed++;
    total++; if (bus.wb_wreg !== 5'd0) $display("FAIL rst_wbreg got %0d want 0", bus.wb_wreg); else passed++;
  endtask

  task automatic test_load_use();
    idv(5'd1, 5'd2, 5'd0, C_LW);
    total++; if (bus.stall !== 1'b0) $display("FAIL lu_nostall got %0d want 0", bus.stall); else passed++;
    tick();
    idv(5'd2, 5'd4, 5'd3, C_R);
    total++; if (bus.stall !== 1'b1) $display("FAIL lu_stall got %0d want 1", bus.stall); else passed++;
    total++; if (bus.ex_memread !== 1'b1) $display("FAIL lu_exmr got %0d want 1", bus.ex_memread); else passed++;
    tick();
    total++; if (bus.stall !== 1'b0) $display("FAIL lu_stall2 got %0d want 0", bus.stall); else passed++;
    total++; if (bus.ex_regwrite !== 1'b0) $display("FAIL lu_bubble got %0d want 0", bus.ex_regwrite); else passed++;
    total++; if (bus.mem_memread !== 1'b1) $display("FAIL lu_memmr got %0d want 1", bus.mem_memread); else passed++;
    total++; if (bus.stall_cnt !== 32'd1) $display("FAIL lu_scnt got %0d want 1", bus.stall_cnt); else passed++;
    tick();
    idv(5'd0, 5'd0, 5'd0, C_NOP);
    total++; if (bus.forward_a !== 2'b01) $display("FAIL lu_fa got %0d want 1", bus.forward_a); else passed++;
    total++; if (bus.forward_b !== 2'b00) $display("FAIL lu_fb got %0d want 0", bus.forward_b); else passed++;
    total++; if (bus.wb_memtoreg !== 1'b1) $display("FAIL lu_wbm2r got %0d want 1", bus.wb_memtoreg); else passed++;
    total++; if (bus.wb_wreg !== 5'd2) $display("FAIL lu_wbreg got %0d want 2", bus.wb_wreg); else passed++;
    drain();
  endtask

  task automatic test_ex_fwd();
    idv(5'd1, 5'd1, 5'd2, C_R);
    tick();
    idv(5'd2, 5'd2, 5'd5, C_R);
    total++; if (bus.stall !== 1'b0) $display("FAIL exf_stall got %0d want 0", bus.stall); else passed++;
    tick();
    idv(5'd0, 5'd0, 5'd0, C_NOP);
    total++; if (bus.forward_a !== 2'b10) $display("FAIL exf_fa got %0d want 2", bus.forward_a); else passed++;
    total++; if (bus.forward_b !== 2'b10) $display("FAIL exf_fb got %0d want 2", bus.forward_b); else passed++;
    drain();
  endtask

  task automatic test_mem_priority();
    idv(5'd1, 5'd1, 5'd2, C_R);
    tick();
    idv(5'd3, 5'd3, 5'd2, C_R);
    tick();
    idv(5'd2, 5'd5, 5'd6, C_R);
    tick();
    idv(5'd0, 5'd0, 5'd0, C_NOP);
    total++; if (bus.forward_a !== 2'b10) $display("FAIL pri_fa got %0d want 2", bus.forward_a); else passed++;
    total++; if (bus.forward_b !== 2'b00) $display("FAIL pri_fb got %0d want 0", bus.forward_b); else passed++;
    drain();
    idv(5'd1, 5'd1, 5'd0, C_R);
    tick();
    idv(5'd0, 5'd0, 5'd7, C_R);
    tick();
    idv(5'd0, 5'd0, 5'd0, C_NOP);
    total++; if (bus.forward_a !== 2'b00) $display("FAIL r0_fa got %0d want 0", bus.forward_a); else passed++;
    total++; if (bus.forward_b !== 2'b00) $display("FAIL r0_fb got %0d want 0", bus.forward_b); else passed++;
    drain();
  endtask

  task automatic test_branch();
    // Control word carrying both branch and memread (dest $2) so a
    // load-use hazard and a taken branch coincide.
    bus.ex_zero = 1'b0;
    idv(5'd3, 5'd2, 5'd0, C_BLD);
    tick();
    idv(5'd2, 5'd4, 5'd3, C_R);
    total++; if (bus.stall !== 1'b1) $display("FAIL br_nt_stall got %0d want 1", bus.stall); else passed++;
    total++; if (bus.pc_redirect !== 2'b00) $display("FAIL br_nt_redir got %0d want 0", bus.pc_redirect); else passed++;
    bus.ex_zero = 1'b1;
    #1;
    total++; if (bus.pc_redirect !== 2'b11) $display("FAIL br_redir got %0d want 3", bus.pc_redirect); else passed++;
    total++; if (bus.flush_ifid !== 1'b1) $display("FAIL br_flush got %0d want 1", bus.flush_ifid); else passed++;
    total++; if (bus.stall !== 1'b0) $display("FAIL br_stall got %0d want 0", bus.stall); else passed++;
    tick();
    bus.ex_zero = 1'b0;
    idv(5'd0, 5'd0, 5'd0, C_NOP);
    total++; if (bus.flush_cnt !== 32'd1) $display("FAIL br_fcnt got %0d want 1", bus.flush_cnt); else passed++;
    total++; if (bus.stall_cnt !== 32'd1) $display("FAIL br_scnt got %0d want 1", bus.stall_cnt); else passed++;
    total++; if (bus.ex_regwrite !== 1'b0) $display("FAIL br_bubble got %0d want 0", bus.ex_regwrite); else passed++;
    drain();
  endtask

  task automatic test_jr();
    idv(5'd1, 5'd31, 5'd0, C_ADDI);
    tick();
    idv(5'd31, 5'd0, 5'd0, C_JR);
    total++; if (bus.stall !== 1'b1) $display("FAIL jr_stall_ex got %0d want 1", bus.stall); else passed++;
    total++; if (bus.flush_ifid !== 1'b0) $display("FAIL jr_flush_ex got %0d want 0", bus.flush_ifid); else passed++;
    tick();
    total++; if (bus.stall !== 1'b1) $display("FAIL jr_stall_mem got %0d want 1", bus.stall); else passed++;
    total++; if (bus.pc_redirect !== 2'b00) $display("FAIL jr_redir_mem got %0d want 0", bus.pc_redirect); else passed++;
    total++; if (bus.stall_cnt !== 32'd2) $display("FAIL jr_scnt1 got %0d want 2", bus.stall_cnt); else passed++;
    tick();
    total++; if (bus.stall !== 1'b0) $display("FAIL jr_go_stall got %0d want 0", bus.stall); else passed++;
    total++; if (bus.pc_redirect !== 2'b10) $display("FAIL jr_redir got %0d want 2", bus.pc_redirect); else passed++;
    total++; if (bus.flush_ifid !== 1'b1) $display("FAIL jr_flush got %0d want 1", bus.flush_ifid); else passed++;
    total++; if (bus.stall_cnt !== 32'd3) $display("FAIL jr_scnt2 got %0d want 3", bus.stall_cnt); else passed++;
    total++; if (bus.wb_wreg !== 5'd31) $display("FAIL jr_wbreg got %0d want 31", bus.wb_wreg); else passed++;
    tick();
    idv(5'd0, 5'd0, 5'd0, C_NOP);
    total++; if (bus.flush_cnt !== 32'd2) $display("FAIL jr_fcnt got %0d want 2", bus.flush_cnt); else passed++;
    total++; if (bus.ex_regwrite !== 1'b0) $display("FAIL jr_bubble got %0d want 0", bus.ex_regwrite); else passed++;
    drain();
  endtask

  task automatic test_jump();
    idv(5'd0, 5'd31, 5'd0, C_JAL);
    total++; if (bus.pc_redirect !== 2'b01) $display("FAIL j_redir got %0d want 1", bus.pc_redirect); else passed++;
    total++; if (bus.flush_ifid !== 1'b1) $display("FAIL j_flush got %0d want 1", bus.flush_ifid); else passed++;
    tick();
    idv(5'd0, 5'd0, 5'd0, C_NOP);
    total++; if (bus.flush_cnt !== 32'd3) $display("FAIL j_fcnt got %0d want 3", bus.flush_cnt); else passed++;
    total++; if (bus.ex_regwrite !== 1'b0) $display("FAIL j_nowrite got %0d want 0", bus.ex_regwrite); else passed++;
    drain();
  endtask

  task automatic test_reset_mid_stall();
    idv(5'd1, 5'd2, 5'd0, C_LW);
    tick();
    idv(5'd2, 5'd4, 5'd3, C_R);
    total++; if (bus.stall !== 1'b1) $display("FAIL rs_pre got %0d want 1", bus.stall); else passed++;
    reset = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) $display("FAIL rs_stall got %0d want 0", bus.stall); else passed++;
    total++; if (bus.pc_redirect !== 2'b00) $display("FAIL rs_redir got %0d want 0", bus.pc_redirect); else passed++;
    tick();
    reset = 1'b0;
    idv(5'd0, 5'd0, 5'd0, C_NOP);
    total++; if (bus.stall_cnt !== 32'd0) $display("FAIL rs_scnt got %0d want 0", bus.stall_cnt); else passed++;
    total++; if (bus.flush_cnt !== 32'd0) $display("FAIL rs_fcnt got %0d want 0", bus.flush_cnt); else passed++;
    total++; if (bus.ex_memread !== 1'b0) $display("FAIL rs_exmr got %0d want 0", bus.ex_memread); else passed++;
    total++; if (bus.mem_memread !== 1'b0) $display("FAIL rs_memmr got %0d want 0", bus.mem_memread); else passed++;
    total++; if (bus.wb_regwrite !== 1'b0) $display("FAIL rs_wbrw got %0d want 0", bus.wb_regwrite); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_load_use();
    test_ex_fwd();
    test_mem_priority();
    test_branch();
    test_jr();
    test_jump();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
